// File: rtl/accum_pp_pipe_if.sv
// Handshake and bus bundle for accum_pp_pipe: framed source beats in, carry-save column vectors out.
// Digit j of source pair i sits at bit offset (i*SRC_COLS + j)*IN_W of src_c/src_s.
interface accum_pp_pipe_if #(
  parameter int NUM_COLS   = 99,
  parameter int NUM_SRC    = 2,
  parameter int SRC_COLS   = 66,
  parameter int IN_W       = 25,
  parameter int EXTRA_COLS = 67,
  parameter int EXTRA_W    = 17,
  parameter int OUT_W      = 20
);
  logic                               in_valid;
  logic                               in_ready;
  logic                               in_first;
  logic                               in_last;
  logic [NUM_SRC*SRC_COLS*IN_W-1:0]   src_c;
  logic [NUM_SRC*SRC_COLS*IN_W-1:0]   src_s;
  logic [EXTRA_COLS*EXTRA_W-1:0]      extra;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_COLS*OUT_W-1:0]          out_c;
  logic [NUM_COLS*OUT_W-1:0]          out_s;
  logic                               err_seq;

  modport master (
    output in_valid, in_first, in_last, src_c, src_s, extra, out_ready,
    input  in_ready, out_valid, out_c, out_s, err_seq
  );

  modport slave (
    input  in_valid, in_first, in_last, src_c, src_s, extra, out_ready,
    output in_ready, out_valid, out_c, out_s, err_seq
  );
endinterface

// File: rtl/accum_pp_pipe.sv
// Multi-beat partial-product accumulator: realigns carry-save source digits into DIGIT_W-weighted
// columns and folds them, plus an offset extra term, into a registered per-column (C,S) pair.
module accum_pp_pipe #(
  parameter int NUM_COLS   = 99,
  parameter int NUM_SRC    = 2,
  parameter int SRC_COLS   = 66,
  parameter int IN_W       = 25,
  parameter int DIGIT_W    = 16,
  parameter int PRE_SHIFT  = 1,
  parameter int EXTRA_COLS = 67,
  parameter int EXTRA_W    = 17,
  parameter int EXTRA_OFS  = 32,
  parameter int OUT_W      = 20
) (
  input logic          clk,
  input logic          rst_n,
  accum_pp_pipe_if.slave bus
);
  localparam int SPLIT    = DIGIT_W - PRE_SHIFT;
  localparam int SRC_BITS = NUM_SRC * SRC_COLS * IN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] acc_c_q [NUM_COLS];
  logic [OUT_W-1:0] acc_c_d [NUM_COLS];
  logic [OUT_W-1:0] acc_s_q [NUM_COLS];
  logic [OUT_W-1:0] acc_s_d [NUM_COLS];
  logic [OUT_W-1:0] col_c   [NUM_COLS];
  logic [OUT_W-1:0] col_s   [NUM_COLS];
  logic             in_rdy;
  logic             accept;
  logic             clear_acc;

  // 3:2 compressor; both outputs keep the column's weight, so carry wraps inside OUT_W.
  function automatic logic [2*OUT_W-1:0] csa3(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b,
                                              input logic [OUT_W-1:0] c);
    logic [OUT_W-1:0] sum_v;
    logic [OUT_W-1:0] maj_v;
    sum_v = a ^ b ^ c;
    maj_v = (a & b) | (a & c) | (b & c);
    return {maj_v << 1, sum_v};
  endfunction

  function automatic logic [IN_W-1:0] src_digit(input logic [SRC_BITS-1:0] arr,
                                                input int i, input int j);
    return arr[(i*SRC_COLS + j)*IN_W +: IN_W];
  endfunction

  function automatic logic [OUT_W-1:0] lo_term(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] t;
    t = '0;
    t[SPLIT-1:0] = d[SPLIT-1:0];
    return t << PRE_SHIFT;
  endfunction

  function automatic logic [OUT_W-1:0] hi_term(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] t;
    t = '0;
    t[IN_W-SPLIT-1:0] = d[IN_W-1:SPLIT];
    return t;
  endfunction

  // Column gather and carry-save reduction onto the (possibly cleared) accumulator.
  always_comb begin
    logic [OUT_W-1:0] c_v, s_v, t_v;
    logic             lo_ok, hi_ok, ex_ok;
    int               lo_j, hi_j, ex_k;
    for (int m = 0; m < NUM_COLS; m++) begin
      lo_ok = (m < SRC_COLS);
      hi_ok = (m >= 1) && (m - 1 < SRC_COLS);
      ex_ok = (m >= EXTRA_OFS) && (m - EXTRA_OFS < EXTRA_COLS);
      lo_j  = lo_ok ? m : 0;
      hi_j  = hi_ok ? m - 1 : 0;
      ex_k  = ex_ok ? m - EXTRA_OFS : 0;
      if (clear_acc) begin
        c_v = '0;
        s_v = '0;
      end else begin
        c_v = acc_c_q[m];
        s_v = acc_s_q[m];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        t_v = lo_ok ? lo_term(src_digit(bus.src_c, i, lo_j)) : '0;
        {c_v, s_v} = csa3(c_v, s_v, t_v);
        t_v = lo_ok ? lo_term(src_digit(bus.src_s, i, lo_j)) : '0;
        {c_v, s_v} = csa3(c_v, s_v, t_v);
        t_v = hi_ok ? hi_term(src_digit(bus.src_c, i, hi_j)) : '0;
        {c_v, s_v} = csa3(c_v, s_v, t_v);
        t_v = hi_ok ? hi_term(src_digit(bus.src_s, i, hi_j)) : '0;
        {c_v, s_v} = csa3(c_v, s_v, t_v);
      end
      t_v = ex_ok ? OUT_W'(bus.extra[ex_k*EXTRA_W +: EXTRA_W]) : '0;
      {c_v, s_v} = csa3(c_v, s_v, t_v);
      col_c[m] = c_v;
      col_s[m] = s_v;
    end
  end

  // Framing FSM: HOLD accepts a new beat only while the result is being consumed.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    clear_acc = 1'b0;
    if (!rst_n) begin
      in_rdy = 1'b0;
    end else if (state_q == HOLD) begin
      in_rdy = bus.out_ready;
    end else begin
      in_rdy = 1'b1;
    end
    accept = bus.in_valid && in_rdy;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          clear_acc = 1'b1;
          err_d     = err_q | ~bus.in_first;
          state_d   = bus.in_last ? HOLD : ACCUM;
        end else if ((state_q == HOLD) && bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ACCUM: begin
        if (accept) begin
          clear_acc = bus.in_first;
          err_d     = err_q | bus.in_first;
          state_d   = bus.in_last ? HOLD : ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Accumulator loads the reduced columns on every accepted beat.
  always_comb begin
    for (int m = 0; m < NUM_COLS; m++) begin
      if (accept) begin
        acc_c_d[m] = col_c[m];
        acc_s_d[m] = col_s[m];
      end else begin
        acc_c_d[m] = acc_c_q[m];
        acc_s_d[m] = acc_s_q[m];
      end
    end
  end

  // State, error flag and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      for (int m = 0; m < NUM_COLS; m++) begin
        acc_c_q[m] <= '0;
        acc_s_q[m] <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int m = 0; m < NUM_COLS; m++) begin
        acc_c_q[m] <= acc_c_d[m];
        acc_s_q[m] <= acc_s_d[m];
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.err_seq   = err_q;

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_out
    assign bus.out_c[g*OUT_W +: OUT_W] = acc_c_q[g];
    assign bus.out_s[g*OUT_W +: OUT_W] = acc_s_q[g];
  end
endmodule

// File: tb/tb_accum_pp_pipe.sv
// Scoreboard bench for accum_pp_pipe: a digit-wise reference model pushes expected column sums
// per frame; each scenario task pops and compares when the DUT presents a result.
module tb_accum_pp_pipe;
  localparam int NUM_COLS   = 99;
  localparam int NUM_SRC    = 2;
  localparam int SRC_COLS   = 66;
  localparam int IN_W       = 25;
  localparam int EXTRA_COLS = 67;
  localparam int EXTRA_W    = 17;
  localparam int EXTRA_OFS  = 32;
  localparam int OUT_W      = 20;
  localparam int SRC_BITS   = NUM_SRC * SRC_COLS * IN_W;
  localparam int EXTRA_BITS = EXTRA_COLS * EXTRA_W;
  localparam int OUT_BITS   = NUM_COLS * OUT_W;
  localparam int COL_MOD    = 1 << OUT_W;
  localparam int LO_SPAN    = 32768;  // a digit's low 15 bits stay in its own column

  logic clk = 1'b0;
  logic rst_n;

  accum_pp_pipe_if bus ();

  accum_pp_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int                  n_checks = 0;
  int                  n_fail   = 0;
  int                  model_acc [NUM_COLS];
  bit                  model_idle;
  logic [OUT_BITS-1:0] sb_q [$];
  logic [SRC_BITS-1:0] stim_c, stim_s;
  logic [EXTRA_BITS-1:0] stim_x;
  int                  bad_col;
  logic [OUT_W-1:0]    bad_got, bad_want;

  function automatic logic [OUT_W-1:0] col_sum(input int m);
    logic [OUT_W-1:0] c, s;
    c = bus.out_c[m*OUT_W +: OUT_W];
    s = bus.out_s[m*OUT_W +: OUT_W];
    return c + s;
  endfunction

  function automatic int count_bad(input logic [OUT_BITS-1:0] exp_v);
    int n;
    n = 0;
    bad_col = -1;
    for (int m = 0; m < NUM_COLS; m++) begin
      if (col_sum(m) !== exp_v[m*OUT_W +: OUT_W]) begin
        if (n == 0) begin
          bad_col  = m;
          bad_got  = col_sum(m);
          bad_want = exp_v[m*OUT_W +: OUT_W];
        end
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [OUT_BITS-1:0] pop_exp();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  task automatic clear_stim();
    stim_c = '0;
    stim_s = '0;
    stim_x = '0;
  endtask

  task automatic rand_stim();
    for (int k = 0; k < NUM_SRC*SRC_COLS; k++) begin
      stim_c[k*IN_W +: IN_W] = IN_W'($urandom);
      stim_s[k*IN_W +: IN_W] = IN_W'($urandom);
    end
    for (int k = 0; k < EXTRA_COLS; k++) stim_x[k*EXTRA_W +: EXTRA_W] = EXTRA_W'($urandom);
  endtask

  task automatic model_clear();
    for (int m = 0; m < NUM_COLS; m++) model_acc[m] = 0;
  endtask

  task automatic model_add();
    int d;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < SRC_COLS; j++) begin
        for (int a = 0; a < 2; a++) begin
          if (a == 0) d = int'(stim_c[(i*SRC_COLS + j)*IN_W +: IN_W]);
          else        d = int'(stim_s[(i*SRC_COLS + j)*IN_W +: IN_W]);
          model_acc[j] = (model_acc[j] + (d % LO_SPAN) * 2) % COL_MOD;
          if (j + 1 < NUM_COLS) model_acc[j+1] = (model_acc[j+1] + d / LO_SPAN) % COL_MOD;
        end
      end
    end
    for (int k = 0; k < EXTRA_COLS; k++) begin
      if (k + EXTRA_OFS < NUM_COLS)
        model_acc[k+EXTRA_OFS] = (model_acc[k+EXTRA_OFS] + int'(stim_x[k*EXTRA_W +: EXTRA_W])) % COL_MOD;
    end
  endtask

  task automatic model_beat(input bit first, input bit last);
    logic [OUT_BITS-1:0] v;
    if (first || model_idle) model_clear();
    model_add();
    model_idle = last;
    if (last) begin
      for (int m = 0; m < NUM_COLS; m++) v[m*OUT_W +: OUT_W] = OUT_W'(model_acc[m]);
      sb_q.push_back(v);
    end
  endtask

  // Drives one beat starting just after a falling edge; returns 1 time unit after the next one.
  task automatic beat(input bit first, input bit last);
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_last  = last;
    bus.src_c    = stim_c;
    bus.src_s    = stim_s;
    bus.extra    = stim_x;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready=%b, expected 1", bus.in_ready);
    end
    model_beat(first, last);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    clear_stim();
    bus.src_c = stim_c;
    bus.src_s = stim_s;
    bus.extra = stim_x;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.out_c !== '0 || bus.out_s !== '0) begin n_fail++; $display("FAIL reset_outputs: out_c/out_s not all zero"); end
    n_checks++;
    if (bus.err_seq !== 1'b0) begin n_fail++; $display("FAIL reset_err_seq: got %b expected 0", bus.err_seq); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    model_idle = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_single_beat();
    int nb;
    clear_stim();
    stim_s[0 +: IN_W] = 25'h1_8001;
    beat(1'b1, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++;
    if (col_sum(0) !== 20'h00002) begin n_fail++; $display("FAIL single_col0: got %h expected 00002", col_sum(0)); end
    n_checks++;
    if (col_sum(1) !== 20'h00003) begin n_fail++; $display("FAIL single_col1: got %h expected 00003", col_sum(1)); end
    nb = count_bad(pop_exp());
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL single_sb: %0d cols differ, col %0d got %h expected %h", nb, bad_col, bad_got, bad_want); end
    n_checks++;
    if (bus.err_seq !== 1'b0) begin n_fail++; $display("FAIL single_err_seq: got %b expected 0", bus.err_seq); end
  endtask

  task automatic test_extra();
    int nb;
    clear_stim();
    stim_x[0 +: EXTRA_W] = 17'h1FFFF;
    beat(1'b1, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL extra_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++;
    if (col_sum(32) !== 20'h1FFFF) begin n_fail++; $display("FAIL extra_col32: got %h expected 1ffff", col_sum(32)); end
    n_checks++;
    if (col_sum(0) !== 20'h00000) begin n_fail++; $display("FAIL extra_col0: got %h expected 00000", col_sum(0)); end
    nb = count_bad(pop_exp());
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL extra_sb: %0d cols differ, col %0d got %h expected %h", nb, bad_col, bad_got, bad_want); end
    n_checks++;
    if (bus.err_seq !== 1'b0) begin n_fail++; $display("FAIL extra_err_seq: got %b expected 0", bus.err_seq); end
  endtask

  task automatic test_multi_beat();
    int nb;
    clear_stim();
    stim_c[(1*SRC_COLS + 65)*IN_W +: IN_W] = 25'h1FF_FFFF;
    beat(1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL multi_mid1_valid: got %b expected 0", bus.out_valid); end
    beat(1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL multi_mid2_valid: got %b expected 0", bus.out_valid); end
    beat(1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL multi_out_valid: got %b expected 1", bus.out_valid); end
    n_checks++;
    if (col_sum(65) !== 20'h2FFFA) begin n_fail++; $display("FAIL multi_col65: got %h expected 2fffa", col_sum(65)); end
    n_checks++;
    if (col_sum(66) !== 20'h00BFD) begin n_fail++; $display("FAIL multi_col66: got %h expected 00bfd", col_sum(66)); end
    nb = count_bad(pop_exp());
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL multi_sb: %0d cols differ, col %0d got %h expected %h", nb, bad_col, bad_got, bad_want); end
  endtask

  task automatic test_back_to_back();
    int nb;
    logic [OUT_BITS-1:0] snap_c, snap_s;
    rand_stim();
    beat(1'b1, 1'b1);
    bus.out_ready = 1'b0;
    nb = count_bad(pop_exp());
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL b2b_first_sb: %0d cols differ, col %0d got %h expected %h", nb, bad_col, bad_got, bad_want); end
    snap_c = bus.out_c;
    snap_s = bus.out_s;
    rand_stim();
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    bus.src_c    = stim_c;
    bus.src_s    = stim_s;
    bus.extra    = stim_x;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b expected 0", bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid: got %b expected 1", bus.out_valid); end
      n_checks++;
      if (bus.out_c !== snap_c || bus.out_s !== snap_s) begin n_fail++; $display("FAIL hold_stable: out_c/out_s changed while stalled"); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    model_beat(1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid: got %b expected 1", bus.out_valid); end
    nb = count_bad(pop_exp());
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL b2b_second_sb: %0d cols differ, col %0d got %h expected %h", nb, bad_col, bad_got, bad_want); end
  endtask

  task automatic test_seq_error();
    int nb;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_idle_valid: got %b expected 0", bus.out_valid); end
    rand_stim();
    beat(1'b0, 1'b0);
    n_checks++;
    if (bus.err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_nonfirst_err: got %b expected 1", bus.err_seq); end
    rand_stim();
    beat(1'b1, 1'b0);
    n_checks++;
    if (bus.err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_restart_err: got %b expected 1", bus.err_seq); end
    rand_stim();
    beat(1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_out_valid: got %b expected 1", bus.out_valid); end
    nb = count_bad(pop_exp());
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL seq_sb: %0d cols differ, col %0d got %h expected %h", nb, bad_col, bad_got, bad_want); end
    n_checks++;
    if (bus.err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_err_sticky: got %b expected 1", bus.err_seq); end
  endtask

  task automatic test_reset_mid();
    int nb;
    rand_stim();
    beat(1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_accum_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_c !== '0 || bus.out_s !== '0) begin n_fail++; $display("FAIL rst_accum_outputs: out_valid=%b, outputs not cleared", bus.out_valid); end
    n_checks++;
    if (bus.err_seq !== 1'b0) begin n_fail++; $display("FAIL rst_accum_err: got %b expected 0", bus.err_seq); end
    rst_n = 1'b1;
    model_idle = 1'b1;
    sb_q.delete();
    rand_stim();
    beat(1'b1, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_c !== '0 || bus.out_s !== '0) begin n_fail++; $display("FAIL rst_hold_outputs: out_valid=%b, outputs not cleared", bus.out_valid); end
    rst_n = 1'b1;
    model_idle = 1'b1;
    sb_q.delete();
    rand_stim();
    beat(1'b1, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_out_valid: got %b expected 1", bus.out_valid); end
    nb = count_bad(pop_exp());
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL post_rst_sb: %0d cols differ, col %0d got %h expected %h", nb, bad_col, bad_got, bad_want); end
    n_checks++;
    if (bus.err_seq !== 1'b0) begin n_fail++; $display("FAIL post_rst_err: got %b expected 0", bus.err_seq); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_extra();
    test_multi_beat();
    test_back_to_back();
    test_seq_error();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d results left, expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "time limit reached");
  end
endmodule

// File: doc/accum_pp_pipe.md
Name: accum_pp_pipe

Overview:
- Parametrised, pipelined successor to the fixed 99-column partial-product accumulator in the squaring datapath.
- Realigns NUM_SRC carry-save source arrays into DIGIT_W-weighted columns and adds an extra column-offset term.
- Compresses each column into a registered carry-save pair (C,S).
- Adds multi-beat accumulation: first/last framing and a valid/ready handshake on both sides, so several partial-product passes fold into one redundant result before the modular reduction stage.

Parameters:
- NUM_COLS, 99, output column count.
- NUM_SRC, 2, number of carry-save source pairs (each pair is one C and one S array).
- SRC_COLS, 66, columns per source array.
- IN_W, 25, bits per source digit.
- DIGIT_W, 16, column weight exponent; column m has weight 2^(DIGIT_W*m).
- PRE_SHIFT, 1, extra left shift applied to source digits; low split = DIGIT_W-PRE_SHIFT bits.
- EXTRA_COLS, 67, columns of the extra term.
- EXTRA_W, 17, bits per extra digit.
- EXTRA_OFS, 32, column offset of the extra term.
- OUT_W, 20, width of each C/S column.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_first  in  1  beat starts a new accumulation.
- in_last  in  1  beat ends the accumulation.
- src_c  in  NUM_SRC*SRC_COLS*IN_W  source carry arrays.
- src_s  in  NUM_SRC*SRC_COLS*IN_W  source sum arrays.
- extra  in  EXTRA_COLS*EXTRA_W  extra term.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&&out_ready.
- out_c  out  NUM_COLS*OUT_W  carry column vector.
- out_s  out  NUM_COLS*OUT_W  sum column vector.
- err_seq  out  1  sticky framing error.

Behaviour:
- Column gathering (combinational), for column m and each source digit d[j] in src_c/src_s:
  - d[j][SPLIT-1:0]<<PRE_SHIFT lands in column j.
  - d[j][IN_W-1:SPLIT] lands in column j+1, where SPLIT=DIGIT_W-PRE_SHIFT.
  - extra[k] lands in column k+EXTRA_OFS.
  - Out-of-range columns contribute zero.
  - All terms are zero-extended to OUT_W.
- Each column is reduced by a CSA tree together with the two accumulator words acc_c[m] and acc_s[m] to a (C,S) pair.
- Invariant per accepted frame: Σm 2^(DIGIT_W·m)(out_c[m]+out_s[m]) equals the sum over beats of Σ 2^(DIGIT_W·j+PRE_SHIFT)(src_c+src_s) + Σ 2^(DIGIT_W(k+EXTRA_OFS))·extra.
- Column width rule: each column value must stay < 2^OUT_W. Callers size OUT_W accordingly; there is no overflow detection, and columns wrap mod 2^OUT_W.
- FSM states are IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1. A beat with in_first clears the accumulator and adds the beat.
    - Beat without in_last → ACCUM.
    - Beat with in_last → HOLD.
  - ACCUM: in_ready=1. A non-first beat adds into the accumulator.
    - Beat with in_last → HOLD.
    - A beat with in_first restarts: the accumulator is cleared and the beat is added. The prior partial is discarded and err_seq is set.
  - HOLD: out_valid=1, in_ready=out_ready.
    - out_ready=1 with no accepted beat → IDLE.
    - out_ready=1 with an accepted beat → the beat is processed as from IDLE in the same cycle (full throughput, no bubble).
- Non-first beat accepted in IDLE: treated as first (accumulator zero) and sets err_seq.
- Latency: out_valid asserts on the cycle after the in_last beat is accepted.
- out_c/out_s are stable while out_valid=1 and !out_ready.
- Single-beat frame (first&last): out_valid on the next cycle.
- Reset (rst_n=0 at a clk edge), also mid-frame or in HOLD: state=IDLE, acc=0, out_c=out_s=0, out_valid=0, err_seq=0. in_ready is 0 during reset and 1 on the first cycle after.
- in_first/in_last/data are ignored when in_valid=0.

Test Plan:
- Default params, single beat first&last, src_s[0][0]=25'h1_8001, all else 0 → next cycle out_valid=1; col0 C+S=0x0002, col1 C+S=0x0003; all other columns 0.
- extra[0]=17'h1FFFF only → column 32 C+S=0x1FFFF; all others 0; err_seq=0.
- Three-beat frame, each beat src_c[1][65]=25'h1FFFFFF → out_valid 1 cycle after beat 3; column 65 sum=3·0xFFFE; column 66 sum=3·0x3FF.
- out_ready held low 5 cycles in HOLD while in_valid=1 → in_ready=0, outputs stable. Then raise out_ready with a new single-beat frame → next frame result appears the following cycle with no bubble.
- Beat without in_first in IDLE, then in_first during ACCUM → err_seq=1 stays set; result equals only the restarted frame.
- rst_n low for one cycle in ACCUM and in HOLD → out_valid=0, outputs 0, err_seq=0. A new single-beat frame afterwards produces the correct sum.
